// File: rtl/game_pkg.sv
// ============================================================================
// game_pkg : shared game state encoding, move codes and screen constants
// Revision : 1.0
// ============================================================================
`default_nettype none

package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_e;

  localparam logic [1:0] MOVE_NONE  = 2'b00;
  localparam logic [1:0] MOVE_LEFT  = 2'b01;
  localparam logic [1:0] MOVE_RIGHT = 2'b10;
  localparam logic [1:0] MOVE_BOTH  = 2'b11;

  localparam int DEF_SCREEN_W     = 640;
  localparam int DEF_PLAYER_W     = 64;
  localparam int DEF_OBJ_W        = 16;
  localparam int DEF_STEP         = 4;
  localparam int DEF_LIVES        = 3;
  localparam int DEF_FLASH_FRAMES = 30;

  localparam logic [15:0] BCD_MAX = 16'h9999;
  localparam logic [15:0] BIN_MAX = 16'hFFFF;

endpackage

`default_nettype wire

// File: rtl/bcd_counter.sv
// ============================================================================
// bcd_counter : 4-digit packed BCD incrementer, saturating at 9999
// Revision    : 1.0
// ============================================================================
`default_nettype none

module bcd_counter
  import game_pkg::*;
(
  input  logic [15:0] value,
  output logic [15:0] incremented
);

  logic [15:0] ripple;
  logic [4:0]  carry;

  assign carry[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      logic [3:0] digit;
      assign digit = value[4*gi +: 4];
      always_comb begin
        ripple[4*gi +: 4] = digit;
        carry[gi+1]       = 1'b0;
        if (carry[gi]) begin
          if (digit == 4'd9) begin
            ripple[4*gi +: 4] = 4'd0;
            carry[gi+1]       = 1'b1;
          end else begin
            ripple[4*gi +: 4] = digit + 4'd1;
          end
        end
      end
    end
  endgenerate

  // A carry out of the top digit only happens from 9999, which must hold.
  assign incremented = (value == BCD_MAX) ? value : ripple;

  logic unused_carry;
  assign unused_carry = carry[4];

endmodule

`default_nettype wire

// File: rtl/game_state.sv
// ============================================================================
// game_state : paddle position, catch/miss resolution, score/lives, game flow
//              BCD_SCORE_EN selects 4-digit BCD score instead of binary.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module game_state
  import game_pkg::*;
#(
  parameter int SCREEN_W     = game_pkg::DEF_SCREEN_W,
  parameter int PLAYER_W     = game_pkg::DEF_PLAYER_W,
  parameter int OBJ_W        = game_pkg::DEF_OBJ_W,
  parameter int STEP         = game_pkg::DEF_STEP,
  parameter int LIVES        = game_pkg::DEF_LIVES,
  parameter int FLASH_FRAMES = game_pkg::DEF_FLASH_FRAMES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic [1:0]  move,
  input  logic [10:0] object_position,
  input  logic        object_landed,
  output logic [10:0] player_x,
  output logic [15:0] score,
  output logic [2:0]  lives,
  output logic        playing,
  output logic        game_over,
  output logic        miss_flash
);

  localparam int FLASH_W = $clog2(FLASH_FRAMES + 1);

  localparam logic [10:0]        X_MAX      = 11'(SCREEN_W - PLAYER_W);
  localparam logic [10:0]        X_CENTRE   = 11'((SCREEN_W - PLAYER_W) / 2);
  localparam logic [10:0]        STEP_X     = 11'(STEP);
  localparam logic [11:0]        OBJ_W_X    = 12'(OBJ_W);
  localparam logic [11:0]        PLAYER_W_X = 12'(PLAYER_W);
  localparam logic [2:0]         LIVES_INIT = 3'(LIVES);
  localparam logic [FLASH_W-1:0] FLASH_LOAD = FLASH_W'(FLASH_FRAMES);
  localparam logic [FLASH_W-1:0] FLASH_ONE  = FLASH_W'(1);

  state_e              state_q, state_d;
  logic [10:0]         player_x_q, player_x_d;
  logic [15:0]         score_q, score_d;
  logic [2:0]          lives_q, lives_d;
  logic [FLASH_W-1:0]  flash_cnt_q, flash_cnt_d;
  logic                miss_flash_q, miss_flash_d;
  logic                playing_q, playing_d;
  logic                game_over_q, game_over_d;

  logic [15:0] score_inc;
  logic [11:0] obj_ext, px_ext;
  logic        hit;

`ifdef BCD_SCORE_EN
  bcd_counter u_bcd_counter (
    .value       (score_q),
    .incremented (score_inc)
  );
`else
  assign score_inc = (score_q == BIN_MAX) ? score_q : score_q + 16'd1;
`endif

  // Widened to 12 bits so the right-edge sums cannot wrap.
  assign obj_ext = {1'b0, object_position};
  assign px_ext  = {1'b0, player_x_q};
  assign hit     = ((obj_ext + OBJ_W_X) > px_ext) && (obj_ext < (px_ext + PLAYER_W_X));

  always_comb begin
    state_d     = state_q;
    player_x_d  = player_x_q;
    score_d     = score_q;
    lives_d     = lives_q;
    flash_cnt_d = flash_cnt_q;

    if (frame_tick && (flash_cnt_q != '0)) begin
      flash_cnt_d = flash_cnt_q - FLASH_ONE;
    end

    case (state_q)
      ST_IDLE: begin
        if (frame_tick && ((move == MOVE_LEFT) || (move == MOVE_RIGHT))) begin
          state_d    = ST_PLAY;
          score_d    = '0;
          lives_d    = LIVES_INIT;
          player_x_d = X_CENTRE;
        end
      end
      ST_PLAY: begin
        if (frame_tick) begin
          if (move == MOVE_LEFT) begin
            player_x_d = (player_x_q < STEP_X) ? 11'd0 : player_x_q - STEP_X;
          end else if (move == MOVE_RIGHT) begin
            player_x_d = (player_x_q > (X_MAX - STEP_X)) ? X_MAX : player_x_q + STEP_X;
          end
        end
        if (object_landed) begin
          if (hit) begin
            score_d = score_inc;
          end else begin
            lives_d     = lives_q - 3'd1;
            flash_cnt_d = FLASH_LOAD;
            if (lives_q == 3'd1) begin
              state_d = ST_OVER;
            end
          end
        end
      end
      ST_OVER: begin
        if (frame_tick && (move == MOVE_BOTH)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    miss_flash_d = (flash_cnt_d != '0);
    playing_d    = (state_d == ST_PLAY);
    game_over_d  = (state_d == ST_OVER);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      player_x_q   <= X_CENTRE;
      score_q      <= '0;
      lives_q      <= LIVES_INIT;
      flash_cnt_q  <= '0;
      miss_flash_q <= 1'b0;
      playing_q    <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      player_x_q   <= player_x_d;
      score_q      <= score_d;
      lives_q      <= lives_d;
      flash_cnt_q  <= flash_cnt_d;
      miss_flash_q <= miss_flash_d;
      playing_q    <= playing_d;
      game_over_q  <= game_over_d;
    end
  end

  assign player_x   = player_x_q;
  assign score      = score_q;
  assign lives      = lives_q;
  assign playing    = playing_q;
  assign game_over  = game_over_q;
  assign miss_flash = miss_flash_q;

endmodule

`default_nettype wire
